// File: rtl/dram_model.sv
// dram_model: behavioural byte-lane DRAM with a fixed request-to-response latency.
// One request (read or write) covers up to 16 byte lanes; the model is busy until
// the response cycle and ignores any request that arrives while busy.
//
// Ports:
//   clk       sole clock, rising edge
//   reset     synchronous, active-high
//   en        per-lane request enable (lane i = byte lane i)
//   rdwr      2'b01 read, 2'b10 write, 2'b00/2'b11 no-op
//   data_in   write byte per lane
//   addr      byte address per lane (only the low log2(DEPTH) bits are used)
//   data_out  read byte per lane, registered; holds its value outside the response cycle
//   valid     per-lane completion strobe, high for the single response cycle
//
// Optional build macro: DRAM_MODEL_TRACE_EN prints one line per enabled lane in
// each response cycle. Without it no trace code is compiled.
module dram_model #(
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       en,
    input  logic [1:0]        rdwr,
    input  logic [15:0][7:0]  data_in,
    input  logic [15:0][63:0] addr,
    output logic [15:0][7:0]  data_out,
    output logic [15:0]       valid
);

    localparam int unsigned LANES = 16;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] OP_RD = 2'b01;
    localparam logic [1:0] OP_WR = 2'b10;

    // Backing store; not reset so preloaded contents survive reset.
    logic [7:0] mem [0:DEPTH-1];

    logic [1:0]                 state2_q, state2_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [LANES-1:0]           en_int_q, en_int_d;
    logic [1:0]                 rdwr_q, rdwr_d;
    logic [LANES-1:0][AW-1:0]   addr_q, addr_d;
    logic [LANES-1:0][7:0]      data_q, data_d;
    logic [LANES-1:0]           valid_q, valid_d;
    logic [LANES-1:0][7:0]      data_out_q, data_out_d;
    logic                       mem_we;
    logic                       unused_addr_hi;

    // Upper address bits are intentionally ignored (addresses wrap modulo DEPTH).
    always_comb begin
        unused_addr_hi = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            unused_addr_hi = unused_addr_hi | (|addr[i][63:AW]);
        end
    end

    // Next-state and response logic.
    always_comb begin
        state2_d   = state2_q;
        cnt_d      = cnt_q;
        en_int_d   = en_int_q;
        rdwr_d     = rdwr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = '0;
        data_out_d = data_out_q;
        mem_we     = 1'b0;

        case (state2_q)
            IDLE: begin
                if ((en != '0) && ((rdwr == OP_RD) || (rdwr == OP_WR))) begin
                    en_int_d = en;
                    rdwr_d   = rdwr;
                    data_d   = data_in;
                    for (int i = 0; i < LANES; i++) begin
                        addr_d[i] = addr[i][AW-1:0];
                    end
                    cnt_d    = CW'(LATENCY - 1);
                    state2_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    // Response is registered on this edge so valid/data_out are
                    // visible during the RESP cycle; the write commits on the same edge.
                    state2_d = RESP;
                    valid_d  = en_int_q;
                    if (rdwr_q == OP_WR) begin
                        data_out_d = '0;
                        mem_we     = 1'b1;
                    end else begin
                        for (int i = 0; i < LANES; i++) begin
                            data_out_d[i] = en_int_q[i] ? mem[addr_q[i]] : 8'h00;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state2_d = IDLE;
            end
            default: begin
                state2_d = IDLE;
            end
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state2_q   <= IDLE;
            cnt_q      <= '0;
            en_int_q   <= '0;
            valid_q    <= '0;
            data_out_q <= '0;
        end else begin
            state2_q   <= state2_d;
            cnt_q      <= cnt_d;
            en_int_q   <= en_int_d;
            valid_q    <= valid_d;
            data_out_q <= data_out_d;
        end
    end

    // Latched request payload; meaningful only while en_int_q is non-zero.
    always_ff @(posedge clk) begin
        rdwr_q <= rdwr_d;
        addr_q <= addr_d;
        data_q <= data_d;
    end

    // Ascending lane order: the highest enabled lane wins on an address collision.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            for (int i = 0; i < LANES; i++) begin
                if (en_int_q[i]) begin
                    mem[addr_q[i]] <= data_q[i];
                end
            end
        end
    end

`ifdef DRAM_MODEL_TRACE_EN
    // Per-lane access trace, one line per enabled lane in the response cycle.
    always_ff @(posedge clk) begin
        if (!reset && (state2_q == RESP)) begin
            for (int i = 0; i < LANES; i++) begin
                if (en_int_q[i]) begin
                    $display("%0t dram_model %s lane %0d addr 0x%0h data 0x%02h",
                             $time, (rdwr_q == OP_WR) ? "WR" : "RD", i, addr_q[i],
                             (rdwr_q == OP_WR) ? data_q[i] : data_out_q[i]);
                end
            end
        end
    end
`endif

    assign data_out = data_out_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_dram_model.sv
// Directed bench for dram_model (DEPTH=4096, LATENCY=2): a table of single
// requests with hand-computed responses, plus sequences for no-op requests,
// requests during BUSY, and reset aborting a write.
module tb_dram_model;

    logic              clk;
    logic              reset;
    logic [15:0]       en;
    logic [1:0]        rdwr;
    logic [15:0][7:0]  data_in;
    logic [15:0][63:0] addr;
    logic [15:0][7:0]  data_out;
    logic [15:0]       valid;

    int checks;
    int failures;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;

    dram_model #(.DEPTH(4096), .LATENCY(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .rdwr     (rdwr),
        .data_in  (data_in),
        .addr     (addr),
        .data_out (data_out),
        .valid    (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]       en;
        logic [1:0]        rdwr;
        logic [15:0][63:0] addr;
        logic [15:0][7:0]  din;
        logic [15:0]       exp_valid;
        logic [15:0][7:0]  exp_dout;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t blank();
        vec_t v;
        v.en        = '0;
        v.rdwr      = 2'b00;
        v.addr      = '0;
        v.din       = '0;
        v.exp_valid = '0;
        v.exp_dout  = '0;
        return v;
    endfunction

    // Accept on the first edge, valid expected two edges later, then idle with held data.
    task automatic run_req(input vec_t v, input string name);
        @(negedge clk);
        en      = v.en;
        rdwr    = v.rdwr;
        addr    = v.addr;
        data_in = v.din;
        @(posedge clk);
        #1;
        en   = '0;
        rdwr = 2'b00;
        chk({name, " accepted"}, 128'(dut.state2_q), 128'(ST_BUSY));
        @(posedge clk);
        #1;
        chk({name, " valid_early"}, 128'(valid), 128'(0));
        @(posedge clk);
        #1;
        chk({name, " valid"}, 128'(valid), 128'(v.exp_valid));
        chk({name, " data_out"}, 128'(data_out), 128'(v.exp_dout));
        @(posedge clk);
        #1;
        chk({name, " valid_after"}, 128'(valid), 128'(0));
        chk({name, " data_hold"}, 128'(data_out), 128'(v.exp_dout));
    endtask

    initial begin
        int pulses;
        logic [15:0] last_valid;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        en       = '0;
        rdwr     = 2'b00;
        addr     = '0;
        data_in  = '0;

        for (int k = 0; k < 11; k++) vecs[k] = blank();

        // 0: write 0x00..0x0F to 0x100..0x10F
        vecs[0].en = 16'hFFFF; vecs[0].rdwr = 2'b10; vecs[0].exp_valid = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            vecs[0].addr[i] = 64'(32'h100 + i);
            vecs[0].din[i]  = 8'(i);
        end
        // 1: read them back
        vecs[1] = vecs[0];
        vecs[1].rdwr = 2'b01; vecs[1].din = '0;
        for (int i = 0; i < 16; i++) vecs[1].exp_dout[i] = 8'(i);
        // 2: fill 0x2F0..0x2FF with 0xC0+i
        vecs[2].en = 16'hFFFF; vecs[2].rdwr = 2'b10; vecs[2].exp_valid = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            vecs[2].addr[i] = 64'(32'h2F0 + i);
            vecs[2].din[i]  = 8'(32'hC0 + i);
        end
        // 3: lane 0 writes 0xA5 to 0x300; disabled lanes point at 0x2F0.. with 0xFF
        vecs[3].en = 16'h0001; vecs[3].rdwr = 2'b10; vecs[3].exp_valid = 16'h0001;
        for (int i = 1; i < 16; i++) begin
            vecs[3].addr[i] = 64'(32'h2F0 + i);
            vecs[3].din[i]  = 8'hFF;
        end
        vecs[3].addr[0] = 64'h300; vecs[3].din[0] = 8'hA5;
        // 4: read 0x300 on lane 0
        vecs[4].en = 16'h0001; vecs[4].rdwr = 2'b01; vecs[4].exp_valid = 16'h0001;
        vecs[4].addr[0] = 64'h300; vecs[4].exp_dout[0] = 8'hA5;
        // 5: 0x2F0..0x2FF unchanged
        vecs[5].en = 16'hFFFF; vecs[5].rdwr = 2'b01; vecs[5].exp_valid = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            vecs[5].addr[i]     = 64'(32'h2F0 + i);
            vecs[5].exp_dout[i] = 8'(32'hC0 + i);
        end
        // 6: write 0x5A to 0x10
        vecs[6].en = 16'h0001; vecs[6].rdwr = 2'b10; vecs[6].exp_valid = 16'h0001;
        vecs[6].addr[0] = 64'h10; vecs[6].din[0] = 8'h5A;
        // 7: read DEPTH+0x10 with high garbage bits -> wraps to 0x10
        vecs[7].en = 16'h0001; vecs[7].rdwr = 2'b01; vecs[7].exp_valid = 16'h0001;
        vecs[7].addr[0] = 64'hFFFF_0000_0000_1010; vecs[7].exp_dout[0] = 8'h5A;
        // 8: lanes 3 and 7 collide on 0x40
        vecs[8].en = 16'h0088; vecs[8].rdwr = 2'b10; vecs[8].exp_valid = 16'h0088;
        vecs[8].addr[3] = 64'h40; vecs[8].din[3] = 8'h11;
        vecs[8].addr[7] = 64'h40; vecs[8].din[7] = 8'h22;
        // 9: read 0x40 on lane 1 -> highest lane's byte
        vecs[9].en = 16'h0002; vecs[9].rdwr = 2'b01; vecs[9].exp_valid = 16'h0002;
        vecs[9].addr[1] = 64'h40; vecs[9].exp_dout[1] = 8'h22;
        // 10: sparse read lanes 0 and 15
        vecs[10].en = 16'h8001; vecs[10].rdwr = 2'b01; vecs[10].exp_valid = 16'h8001;
        vecs[10].addr[0] = 64'h105; vecs[10].exp_dout[0] = 8'h05;
        vecs[10].addr[15] = 64'h10F; vecs[10].exp_dout[15] = 8'h0F;
        for (int i = 1; i < 15; i++) vecs[10].addr[i] = 64'h300;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset valid", 128'(valid), 128'(0));
        chk("reset data_out", 128'(data_out), 128'(0));
        chk("reset state2", 128'(dut.state2_q), 128'(ST_IDLE));
        chk("reset counter", 128'(dut.cnt_q), 128'(0));
        chk("reset en_int", 128'(dut.en_int_q), 128'(0));

        for (int k = 0; k < 11; k++) begin
            run_req(vecs[k], $sformatf("vec%0d", k));
        end
        chk("mem 0x40", 128'(dut.mem['h40]), 128'(8'h22));
        chk("mem 0x300", 128'(dut.mem['h300]), 128'(8'hA5));
        chk("mem 0x2F5", 128'(dut.mem['h2F5]), 128'(8'hC5));

        // No-op rdwr=11 and en=0 are never accepted.
        @(negedge clk);
        en = 16'hFFFF; rdwr = 2'b11; addr = '0; data_in = '1;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (valid != '0 || dut.state2_q != ST_IDLE) pulses++;
        end
        en = '0; rdwr = 2'b01;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (valid != '0 || dut.state2_q != ST_IDLE) pulses++;
        end
        rdwr = 2'b00;
        chk("noop ignored", 128'(pulses), 128'(0));
        chk("noop mem", 128'(dut.mem[0]), 128'(8'h00));

        // Second request during BUSY is dropped; payload changes after accept are ignored.
        @(negedge clk);
        en = 16'h0001; rdwr = 2'b10; addr = '0; data_in = '0;
        addr[0] = 64'h500; data_in[0] = 8'h77;
        @(posedge clk);
        @(negedge clk);
        data_in[0] = 8'h99;
        pulses = 0;
        last_valid = '0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (valid != '0) begin
                pulses++;
                last_valid = valid;
            end
            if (c == 1) begin
                en = '0;
                rdwr = 2'b00;
            end
        end
        chk("busy pulses", 128'(pulses), 128'(1));
        chk("busy valid", 128'(last_valid), 128'(16'h0001));
        chk("busy mem", 128'(dut.mem['h500]), 128'(8'h77));

        // Reset in BUSY of a write aborts it.
        begin
            vec_t v;
            v = blank();
            v.en = 16'h0001; v.rdwr = 2'b10; v.exp_valid = 16'h0001;
            v.addr[0] = 64'h600; v.din[0] = 8'h44;
            run_req(v, "preload600");
        end
        @(negedge clk);
        en = 16'h0001; rdwr = 2'b10; addr = '0; data_in = '0;
        addr[0] = 64'h600; data_in[0] = 8'h33;
        @(posedge clk);
        #1;
        en = '0; rdwr = 2'b00;
        chk("abort in busy", 128'(dut.state2_q), 128'(ST_BUSY));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (valid != '0) pulses++;
        end
        chk("abort valid", 128'(pulses), 128'(0));
        chk("abort state2", 128'(dut.state2_q), 128'(ST_IDLE));
        chk("abort mem", 128'(dut.mem['h600]), 128'(8'h44));

        // Contents written before reset survive it.
        run_req(vecs[1], "post_reset_read");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
